// File: rtl/fetch_pkg.sv
// Shared types and constants for the 16-bit MIPS instruction fetch stage.
package fetch_pkg;

    localparam int INSTR_W = 16;
    localparam int PC_W    = 16;

    localparam logic [PC_W-1:0]    PC_STEP    = 16'd2;
    localparam logic [INSTR_W-1:0] HALT_INSTR = 16'hFFFF;
    localparam logic [INSTR_W-1:0] NOP_INSTR  = 16'h0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO of {instr, pc} entries with a single-cycle flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t wr_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             push_eff;

    // A flush wins over a same-cycle push so no stale word survives it.
    assign push_eff = push && !flush;

    always_ff @(posedge clock) begin
        if (push_eff)
            mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push_eff)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push_eff) - CNT_W'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, halt detection and redirect around the prefetch queue.
// Optional FETCH_PERF_EN adds fetch_count/stall_count performance counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               DEPTH    = 4,
    parameter logic [PC_W-1:0]  RESET_PC = 16'h0000
) (
    input  logic               clock,
    input  logic               reset,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc,
    output logic               halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        fetch_count,
    output logic [15:0]        stall_count
`endif
);

    logic [PC_W-1:0] fetch_pc;
    logic            halt_seen;
    logic            halted_q;
    logic            push;
    logic            pop;
    logic            q_full;
    logic            q_empty;
    fetch_entry_t    head;
    fetch_entry_t    wr_entry;

    assign id_valid = !q_empty;
    assign id_instr = q_empty ? NOP_INSTR : head.instr;
    assign id_pc    = q_empty ? '0 : head.pc;
    assign pop      = id_valid && id_ready;
    assign push     = !halt_seen && !redirect_valid && (!q_full || pop);

    assign wr_entry.instr = imem_data;
    assign wr_entry.pc    = fetch_pc;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .wr_entry (wr_entry),
        .pop      (pop),
        .flush    (redirect_valid),
        .head     (head),
        .full     (q_full),
        .empty    (q_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            halt_seen <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            if (redirect_valid) begin
                fetch_pc  <= redirect_pc & ~PC_W'(1);
                halt_seen <= 1'b0;
            end else if (push) begin
                fetch_pc <= fetch_pc + PC_STEP;
                if (imem_data == HALT_INSTR)
                    halt_seen <= 1'b1;
            end
            // Popping the halt word counts even when a redirect flushes the queue.
            if (pop && head.instr == HALT_INSTR)
                halted_q <= 1'b1;
        end
    end

    assign imem_addr = fetch_pc;
    assign halted    = halted_q;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (push)
                fetch_count <= fetch_count + 16'd1;
            if (id_valid && !id_ready)
                stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the 16-bit simplified MIPS pipeline. It drives the asynchronous-read instruction memory with a byte-addressed PC and buffers fetched words in a small prefetch queue. It hands each word and its PC downstream to the decode/control stage over a valid/ready handshake. It also detects the halt word (16'hFFFF), stops fetching after it, and accepts PC redirects from later stages.

## Interface
Parameters:
- DEPTH, 4, prefetch queue entries; power of two, ≥2
- RESET_PC, 16'h0000, PC loaded on reset; bit 0 must be 0

Ports:
- clock  in  1  sole clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- imem_addr  out  16  byte address to instruction memory (= fetch_pc)
- imem_data  in  16  instruction word, valid combinationally in the same cycle
- redirect_valid  in  1  one-cycle pulse: flush and refetch from redirect_pc
- redirect_pc  in  16  redirect target; bit 0 ignored (forced 0)
- id_valid  out  1  queue head holds an instruction
- id_ready  in  1  decode accepts the head this cycle
- id_instr  out  16  head instruction; 16'h0000 when empty
- id_pc  out  16  byte PC of head instruction; 16'h0000 when empty
- halted  out  1  halt word has been accepted by decode; sticky

## Operation
- State: fetch_pc, halt_seen, halted, and a circular queue of {instr, pc} with rd_ptr, wr_ptr, and count (0..DEPTH).
- Push condition: !halt_seen && !redirect_valid && (count < DEPTH || pop). Pushes {imem_data, fetch_pc}. fetch_pc <= fetch_pc + 2, modulo 2^16, so 16'hFFFE wraps to 16'h0000.
- Pop condition: id_valid && id_ready. Advances rd_ptr.
- Simultaneous push and pop when full is allowed; count stays DEPTH.
- Halt: a pushed word equal to 16'hFFFF sets halt_seen. No further pushes occur; words already queued still drain in order.
- When the halt word is popped, halted <= 1 and stays set until reset.
- Redirect has priority over push:
  - Any pop in the same cycle still completes.
  - The queue is then emptied: count <= 0, rd_ptr = wr_ptr.
  - fetch_pc <= {redirect_pc[15:1],1'b0}; halt_seen <= 0.
  - halted is unaffected.
- If the halt word is popped in the same cycle as a redirect, halted still sets.
- Pointers wrap modulo DEPTH.
- Reset values:
  - fetch_pc/imem_addr = RESET_PC
  - id_valid = 0, id_instr = 0, id_pc = 0
  - halted = 0, halt_seen = 0
  - count = 0, both pointers 0
- Reset overrides redirect and handshake in the same cycle. Reset mid-operation discards all queued entries.

## Timing
- First word: pushed on the first posedge after reset deasserts. id_valid rises on the following cycle, so latency is 1 cycle from address to head.
- With id_ready held high and no redirect, one instruction issues per cycle. id_pc advances by 2 every cycle.
- Redirect asserted in cycle t:
  - id_valid = 0 in cycle t+1, with imem_addr = target.
  - The first target instruction is presented in cycle t+2.
- id_instr and id_pc are registered/queue outputs. They depend on no combinational input, which breaks any timing path from id_ready to imem_addr.
- halted rises in the cycle after the halt word's handshake.
- After the halt word is pushed, imem_addr holds the halt word's address + 2 and does not advance.

## Configuration
- FETCH_PERF_EN defined adds two output ports:
  - fetch_count (16 bits): counts pushes.
  - stall_count (16 bits): counts cycles with id_valid && !id_ready.
  - Both reset to 0, wrap at 16'hFFFF→0, and are unaffected by redirect.
- FETCH_PERF_EN undefined: the ports and counters are absent. Functional behaviour is identical.

## Structure
- Shared package fetch_pkg:
  - INSTR_W = 16, PC_W = 16
  - PC_STEP = 16'd2
  - HALT_INSTR = 16'hFFFF
  - NOP_INSTR = 16'h0000
  - fetch_entry_t typedef {instr, pc}
- Sub-module fetch_queue: a parameterised circular FIFO of fetch_entry_t with push, pop, flush, full, and empty. fetch_unit contains the PC, halt, and redirect logic around it.

## Test plan
- Sequential fetch: memory preloaded with addi 15, addi 7, and, halt; id_ready=1 → id_pc 0,2,4,6 on consecutive cycles; halted=1 one cycle after pc 6 issues; imem_addr frozen at 8.
- Backpressure: id_ready=0 for 6 cycles from reset → count saturates at 4, imem_addr stops at 8, head stays pc 0. Release → pcs 0..6 issue, with no gap, duplicate, or loss.
- Redirect: redirect_valid with redirect_pc=16'h0021 while 3 entries are queued → next cycle id_valid=0, imem_addr=16'h0020. Following cycle id_pc=16'h0020.
- Simultaneous pop and redirect, with the head being the halt word → halted=1 and queue flushed; fetching resumes at the target.
- Wrap: RESET_PC=16'hFFFC → id_pc FFFC, FFFE, 0000, 0002.
- Reset mid-stream after 5 issues → next cycle id_valid=0, imem_addr=RESET_PC, halted=0. With FETCH_PERF_EN, both counters read 0.
